// File: rtl/video_pkg.sv
// Shared constants and 2513-style 5x7 glyph table for the dot serializer.
// Codes follow ASCII & 6'h3F; row 7 is the inter-line blank.
package video_pkg;

  localparam int CHARS_PER_LINE = 40;
  localparam int CELL_W         = 7;
  localparam int SHIFT_W        = 7;
  localparam int GLYPH_W        = 5;
  localparam logic [5:0] CURSOR_CODE = 6'h00;

  typedef logic [GLYPH_W-1:0] glyph_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } ser_state_t;

  localparam glyph_row_t CHAR_ROM [64][8] = '{
    '{5'h0E,5'h11,5'h15,5'h17,5'h16,5'h10,5'h0F,5'h00},
    '{5'h04,5'h0A,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h00},
    '{5'h1E,5'h11,5'h11,5'h1E,5'h11,5'h11,5'h1E,5'h00},
    '{5'h0E,5'h11,5'h10,5'h10,5'h10,5'h11,5'h0E,5'h00},
    '{5'h1E,5'h11,5'h11,5'h11,5'h11,5'h11,5'h1E,5'h00},
    '{5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h1F,5'h00},
    '{5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h10,5'h00},
    '{5'h0F,5'h10,5'h10,5'h13,5'h11,5'h11,5'h0F,5'h00},
    '{5'h11,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11,5'h00},
    '{5'h0E,5'h04,5'h04,5'h04,5'h04,5'h04,5'h0E,5'h00},
    '{5'h01,5'h01,5'h01,5'h01,5'h01,5'h11,5'h0E,5'h00},
    '{5'h11,5'h12,5'h14,5'h18,5'h14,5'h12,5'h11,5'h00},
    '{5'h10,5'h10,5'h10,5'h10,5'h10,5'h10,5'h1F,5'h00},
    '{5'h11,5'h1B,5'h15,5'h15,5'h11,5'h11,5'h11,5'h00},
    '{5'h11,5'h11,5'h19,5'h15,5'h13,5'h11,5'h11,5'h00},
    '{5'h0E,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E,5'h00},
    '{5'h1E,5'h11,5'h11,5'h1E,5'h10,5'h10,5'h10,5'h00},
    '{5'h0E,5'h11,5'h11,5'h11,5'h15,5'h12,5'h0D,5'h00},
    '{5'h1E,5'h11,5'h11,5'h1E,5'h14,5'h12,5'h11,5'h00},
    '{5'h0E,5'h11,5'h10,5'h0E,5'h01,5'h11,5'h0E,5'h00},
    '{5'h1F,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04,5'h00},
    '{5'h11,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E,5'h00},
    '{5'h11,5'h11,5'h11,5'h11,5'h11,5'h0A,5'h04,5'h00},
    '{5'h11,5'h11,5'h11,5'h15,5'h15,5'h1B,5'h11,5'h00},
    '{5'h11,5'h11,5'h0A,5'h04,5'h0A,5'h11,5'h11,5'h00},
    '{5'h11,5'h11,5'h0A,5'h04,5'h04,5'h04,5'h04,5'h00},
    '{5'h1F,5'h01,5'h02,5'h04,5'h08,5'h10,5'h1F,5'h00},
    '{5'h1E,5'h18,5'h18,5'h18,5'h18,5'h18,5'h1E,5'h00},
    '{5'h00,5'h10,5'h08,5'h04,5'h02,5'h01,5'h00,5'h00},
    '{5'h0F,5'h03,5'h03,5'h03,5'h03,5'h03,5'h0F,5'h00},
    '{5'h04,5'h0E,5'h15,5'h04,5'h04,5'h04,5'h04,5'h00},
    '{5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h1F,5'h00},
    '{5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00},
    '{5'h04,5'h04,5'h04,5'h04,5'h04,5'h00,5'h04,5'h00},
    '{5'h0A,5'h0A,5'h0A,5'h00,5'h00,5'h00,5'h00,5'h00},
    '{5'h0A,5'h0A,5'h1F,5'h0A,5'h1F,5'h0A,5'h0A,5'h00},
    '{5'h04,5'h0F,5'h14,5'h0E,5'h05,5'h1E,5'h04,5'h00},
    '{5'h18,5'h19,5'h02,5'h04,5'h08,5'h13,5'h03,5'h00},
    '{5'h08,5'h14,5'h14,5'h08,5'h15,5'h12,5'h0D,5'h00},
    '{5'h04,5'h04,5'h04,5'h00,5'h00,5'h00,5'h00,5'h00},
    '{5'h04,5'h08,5'h10,5'h10,5'h10,5'h08,5'h04,5'h00},
    '{5'h04,5'h02,5'h01,5'h01,5'h01,5'h02,5'h04,5'h00},
    '{5'h04,5'h15,5'h0E,5'h04,5'h0E,5'h15,5'h04,5'h00},
    '{5'h00,5'h04,5'h04,5'h1F,5'h04,5'h04,5'h00,5'h00},
    '{5'h00,5'h00,5'h00,5'h00,5'h04,5'h04,5'h08,5'h00},
    '{5'h00,5'h00,5'h00,5'h1F,5'h00,5'h00,5'h00,5'h00},
    '{5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h04,5'h00},
    '{5'h00,5'h01,5'h02,5'h04,5'h08,5'h10,5'h00,5'h00},
    '{5'h0E,5'h11,5'h13,5'h15,5'h19,5'h11,5'h0E,5'h00},
    '{5'h04,5'h0C,5'h04,5'h04,5'h04,5'h04,5'h0E,5'h00},
    '{5'h0E,5'h11,5'h01,5'h06,5'h08,5'h10,5'h1F,5'h00},
    '{5'h1F,5'h01,5'h02,5'h06,5'h01,5'h11,5'h0E,5'h00},
    '{5'h02,5'h06,5'h0A,5'h12,5'h1F,5'h02,5'h02,5'h00},
    '{5'h1F,5'h10,5'h1E,5'h01,5'h01,5'h11,5'h0E,5'h00},
    '{5'h07,5'h08,5'h10,5'h1E,5'h11,5'h11,5'h0E,5'h00},
    '{5'h1F,5'h01,5'h02,5'h04,5'h08,5'h08,5'h08,5'h00},
    '{5'h0E,5'h11,5'h11,5'h0E,5'h11,5'h11,5'h0E,5'h00},
    '{5'h0E,5'h11,5'h11,5'h0F,5'h01,5'h02,5'h1C,5'h00},
    '{5'h00,5'h00,5'h04,5'h00,5'h04,5'h00,5'h00,5'h00},
    '{5'h00,5'h00,5'h04,5'h00,5'h04,5'h04,5'h08,5'h00},
    '{5'h02,5'h04,5'h08,5'h10,5'h08,5'h04,5'h02,5'h00},
    '{5'h00,5'h00,5'h1F,5'h00,5'h1F,5'h00,5'h00,5'h00},
    '{5'h08,5'h04,5'h02,5'h01,5'h02,5'h04,5'h08,5'h00},
    '{5'h0E,5'h11,5'h02,5'h04,5'h04,5'h00,5'h04,5'h00}
  };

endpackage

// File: rtl/video_dot_serializer_if.sv
// Line-buffer link: character/cursor from the buffer, advance strobe back.
interface video_dot_serializer_if;

  logic [5:0] char_in;
  logic       cursor_in;
  logic       char_adv;

  modport master (
    output char_in,
    output cursor_in,
    input  char_adv
  );

  modport slave (
    input  char_in,
    input  cursor_in,
    output char_adv
  );

endinterface

// File: rtl/video_dot_serializer_rom.sv
// 2513-equivalent character ROM, combinational code/row -> 5 glyph dots.
module char_rom_2513
  import video_pkg::*;
(
    input  logic [5:0] code,
    input  logic [2:0] row,
    output logic [4:0] dots
);

    always_comb begin
        dots = '0;
        if (row != 3'd7) begin
            dots = CHAR_ROM[code][row];
        end
    end

endmodule

// File: rtl/video_dot_serializer.sv
// Loads one glyph row per 7-dot cell, shifts it out MSB first, and
// strobes the line buffer once per loaded cell.
module video_dot_serializer
  import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot_en,
    input  logic       h_active,
    input  logic       v_active,
    input  logic [2:0] row,
    video_dot_serializer_if.slave lb,
    output logic       video_out,
    output logic       line_done
);

    localparam int DOT_W = $clog2(CELL_W);
    localparam int CNT_W = $clog2(CHARS_PER_LINE + 1);
    localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(CELL_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHARS_PER_LINE - 1);

    ser_state_t         state_q, state_d;
    logic [SHIFT_W-1:0] shreg_q, shreg_d;
    logic [DOT_W-1:0]   dot_q, dot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vid_q, vid_d;
    logic               adv_q, adv_d;
    logic               done_q, done_d;

    logic [5:0]         code;
    logic [4:0]         dots;
    logic               blank_dot;
    logic               load_dot;
    logic               shift_dot;

    assign code = lb.cursor_in ? CURSOR_CODE : lb.char_in;

    char_rom_2513 u_rom (
        .code (code),
        .row  (row),
        .dots (dots)
    );

    // DRAIN stands for "all cells of this line already loaded"
    assign blank_dot = dot_en & ~h_active;
    assign load_dot  = dot_en & h_active & (dot_q == '0)
                     & (state_q != ST_DRAIN);
    assign shift_dot = dot_en & h_active & ~load_dot;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dot_d   = dot_q;
        cnt_d   = cnt_q;
        vid_d   = vid_q;
        adv_d   = 1'b0;
        done_d  = 1'b0;
        unique case (1'b1)
            blank_dot: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                dot_d   = '0;
                cnt_d   = '0;
                vid_d   = 1'b0;
            end
            load_dot: begin
                vid_d   = shreg_q[SHIFT_W-1] & v_active;
                dot_d   = (dot_q == DOT_LAST) ? '0 : dot_q + 1'b1;
                shreg_d = {dots, {(SHIFT_W-GLYPH_W){1'b0}}};
                adv_d   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_ACTIVE;
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            shift_dot: begin
                vid_d   = shreg_q[SHIFT_W-1] & v_active;
                dot_d   = (dot_q == DOT_LAST) ? '0 : dot_q + 1'b1;
                shreg_d = shreg_q << 1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dot_q   <= '0;
            cnt_q   <= '0;
            vid_q   <= 1'b0;
            adv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dot_q   <= dot_d;
            cnt_q   <= cnt_d;
            vid_q   <= vid_d;
            adv_q   <= adv_d;
            done_q  <= done_d;
        end
    end

    assign video_out   = vid_q;
    assign line_done   = done_q;
    assign lb.char_adv = adv_q;

endmodule

// File: doc/video_dot_serializer.md
Name: video_dot_serializer

Overview:
- Downstream neighbour of the 40x6 line-buffer shift register; it consumes the 6-bit character code at the line-buffer output.
- Looks up the 5-dot glyph row in a 2513-equivalent character ROM and serialises it as 7 dots per character cell (5 glyph dots plus 2 blank dots).
- Generates the one-clock advance strobe that steps the line buffer.
- Output feeds the video mixer/sync stage as a single-bit dot stream.

Parameters:
- CHARS_PER_LINE, 40, character cells displayed per active line.
- CELL_W, 7, dots per cell; the low 2 dots are always blank.
- CURSOR_CODE, 6'h00, code substituted while cursor_in is high ('@').

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- dot_en  in  1  one-clk pulse per dot period; all state advances only on dot_en.
- h_active  in  1  horizontal active window; level, sampled on dot_en.
- v_active  in  1  vertical active window.
- row  in  3  glyph scanline 0..7; row 7 is the inter-line blank.
- char_in  in  6  character code from the line-buffer output.
- cursor_in  in  1  current cell is the cursor (blink already applied upstream).
- char_adv  out  1  one-clk pulse; enables the line buffer to shift one position.
- video_out  out  1  registered serial dot, 1 = lit.
- line_done  out  1  one-clk pulse after the 40th cell has been loaded.

Behaviour:
- Reset: all outputs 0; shreg=0, dot_cnt=0, char_cnt=0, done flag clear. Reset is async assert and sync-style deassert with no further handling.
- Nothing changes on cycles without dot_en, except that char_adv and line_done return to 0 one clk after they pulse.
- On dot_en with h_active=0: dot_cnt=0, char_cnt=0, done cleared, shreg=0, video_out=0.
- On dot_en with h_active=1, dot_cnt==0 and char_cnt<CHARS_PER_LINE (load cycle):
  - code = cursor_in ? CURSOR_CODE : char_in.
  - shreg <= {rom(code,row)[4:0], 2'b00}.
  - char_adv <= 1.
  - char_cnt++.
  - If the new char_cnt == CHARS_PER_LINE, then line_done <= 1.
- Otherwise, on dot_en with h_active=1: shreg shifts left by 1 with zero fill.
- dot_cnt counts 0..CELL_W-1 and wraps to 0 on each dot_en while h_active=1.
- video_out <= shreg[6] & v_active, registered on each dot_en.
- Latency: the first glyph dot (MSB, leftmost) appears on video_out at the dot_en after the load, and each dot is held for exactly one dot period.
- After CHARS_PER_LINE loads: no further char_adv; shreg drains to 0, so video_out=0 until h_active falls.
- h_active falling mid-cell truncates the cell immediately. The line buffer has advanced only by the number of loads already performed.
- row==7 or v_active=0: the ROM returns 0 for row 7, and v_active gates the output. char_adv still pulses so that line-buffer recirculation stays aligned.
- Simultaneous cursor_in with any char_in: the cursor code wins; char_in is ignored but still consumed (char_adv pulses).
- char_in is sampled only in the load cycle and may change freely at other times.

Decomposition:
- Package video_pkg holds:
  - the CHAR_ROM constant: 64x8 entries of 5 bits, in 2513 glyph order with code = ASCII & 6'h3F;
  - CELL_W, CHARS_PER_LINE and CURSOR_CODE;
  - the dot-shift width constant (7).
- Sub-module char_rom_2513: combinational lookup (code[5:0], row[2:0]) -> dots[4:0], returning 0 for row 7. It is kept separate so the future full-screen path can reuse it.

Test Plan:
- Reset: hold rst_n=0 mid-line with a pattern loaded -> video_out, char_adv and line_done are 0 asynchronously; after release, the first load occurs on the first dot_en with h_active=1.
- 'H' row 0: char_in=6'h08, row=0, v_active=1, one cell -> video_out over 7 dot periods = 1,0,0,0,1,0,0; exactly one char_adv.
- 'H' row 3: char_in=6'h08, row=3 -> dots 1,1,1,1,1,0,0.
- Cursor: cursor_in=1, char_in=6'h08 -> '@' glyph row emitted and char_adv still pulses once.
- Full line: h_active held for 300 dots -> exactly 40 char_adv pulses 7 dot periods apart; line_done asserted once, together with the 40th char_adv; video_out=0 after dot 280.
- Truncation and blanking:
  - h_active dropped at dot 3 of cell 5 -> video_out 0 at the next dot_en, char_cnt restarts at 0 on the next line, 5 char_adv total.
  - row=7 with char_in=6'h08 -> all-zero output but char_adv still pulses.
